// File: rtl/sequence_generator_if.sv
// Control and serial-stream bundle between a pattern requester and sequence_generator.
// The controller drives the request fields; the generator returns the qualified bit stream and status.
interface sequence_generator_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic [GAP_W-1:0] gap;
  logic             abort;
  logic             data;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, reps, gap, abort,
    input  data, valid, busy, done
  );

  modport slave (
    input  start, pattern, reps, gap, abort,
    output data, valid, busy, done
  );
endinterface

// File: rtl/sequence_generator.sv
// Serial pattern transmitter: shifts a latched pattern out MSB-first, repeated reps times
// with gap idle cycles in between; all outputs registered, first bit one cycle after accept.
module sequence_generator #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  sequence_generator_if.slave  bus
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] reps_q, reps_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [GAP_W-1:0] gcnt_q, gcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             data_q, data_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [IDX_W-1:0] idx_dec;

  assign idx_dec = idx_q - 1'b1;

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    reps_d  = reps_q;
    gap_d   = gap_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    data_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.reps != '0)) begin
          pat_d   = bus.pattern;
          reps_d  = bus.reps;
          gap_d   = bus.gap;
          idx_d   = MSB_IDX;
          state_d = SEND;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = bus.pattern[PAT_W-1];
        end
      end

      SEND: begin
        // abort outranks both bit advance and normal completion
        if (bus.abort) begin
          state_d = IDLE;
        end else if (idx_q != '0) begin
          idx_d   = idx_dec;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = pat_q[idx_dec];
        end else if (reps_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          reps_d = reps_q - 1'b1;
          busy_d = 1'b1;
          if (gap_q != '0) begin
            state_d = GAP;
            gcnt_d  = gap_q;
          end else begin
            idx_d   = MSB_IDX;
            valid_d = 1'b1;
            data_d  = pat_q[PAT_W-1];
          end
        end
      end

      GAP: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (gcnt_q == GAP_W'(1)) begin
          state_d = SEND;
          idx_d   = MSB_IDX;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          data_d  = pat_q[PAT_W-1];
        end else begin
          gcnt_d = gcnt_q - 1'b1;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      reps_q  <= '0;
      gap_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      reps_q  <= reps_d;
      gap_q   <= gap_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: each scenario compares per-cycle
// {data,valid,busy,done} against a cycle list built from the transfer rules.
module tb_sequence_generator;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] exp_q[$];

  sequence_generator_if #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) sif ();

  sequence_generator #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif)
  );

  wire [3:0] obs = {sif.data, sif.valid, sif.busy, sif.done};

  always #5 clk = ~clk;

  // Expected cycles following an accepting edge: every repetition's bits MSB-first,
  // gap silent-but-busy cycles between repetitions, then one done cycle.
  function automatic void model_transfer(input logic [PAT_W-1:0] p, input int r, input int g);
    for (int rep = 0; rep < r; rep++) begin
      for (int i = PAT_W - 1; i >= 0; i--) exp_q.push_back({p[i], 1'b1, 1'b1, 1'b0});
      if (rep != r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
  endfunction

  task automatic scramble_inputs();
    sif.pattern = PAT_W'($urandom);
    sif.reps    = CNT_W'($urandom);
    sif.gap     = GAP_W'($urandom);
  endtask

  task automatic test_reset();
    sif.start = 1'b0; sif.abort = 1'b0;
    sif.pattern = '0; sif.reps = '0; sif.gap = '0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_async got %b want 0000", obs); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_held got %b want 0000", obs); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_idle got %b want 0000", obs); end
  endtask

  task automatic test_directed();
    logic [PAT_W-1:0] pats [5] = '{4'b1010, 4'b1010, 4'b1101, 4'b0110, 4'b1001};
    int               rs   [5] = '{1, 3, 2, 15, 2};
    int               gs   [5] = '{0, 2, 0, 7, 1};
    for (int t = 0; t < 5; t++) begin
      sif.pattern = pats[t]; sif.reps = CNT_W'(rs[t]); sif.gap = GAP_W'(gs[t]);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      scramble_inputs();
      exp_q.delete();
      model_transfer(pats[t], rs[t], gs[t]);
      exp_q.push_back(4'b0000);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs !== exp_q[k]) begin
          errors++;
          $display("FAIL directed case %0d cycle %0d got %b want %b", t, k, obs, exp_q[k]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    sif.pattern = 4'b1010; sif.reps = CNT_W'(1); sif.gap = '0;
    sif.start = 1'b1;
    @(negedge clk);
    exp_q.delete();
    for (int n = 0; n < 3; n++) model_transfer(4'b1010, 1, 0);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs !== exp_q[k]) begin
        errors++;
        $display("FAIL back_to_back cycle %0d got %b want %b", k, obs, exp_q[k]);
      end
      if (k == 14) sif.start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_abort();
    int rs [3] = '{2, 2, 1};
    int gs [3] = '{0, 3, 0};
    int ak [3] = '{1, 5, 3};
    logic [PAT_W-1:0] p;
    for (int t = 0; t < 3; t++) begin
      p = PAT_W'($urandom);
      sif.pattern = p; sif.reps = CNT_W'(rs[t]); sif.gap = GAP_W'(gs[t]);
      sif.start = 1'b1;
      @(negedge clk);
      exp_q.delete();
      model_transfer(p, rs[t], gs[t]);
      for (int k = 0; k <= ak[t]; k++) begin
        checks++;
        if (obs !== exp_q[k]) begin
          errors++;
          $display("FAIL abort_pre case %0d cycle %0d got %b want %b", t, k, obs, exp_q[k]);
        end
        // start stays high so abort must also win over a competing request
        if (k == ak[t]) sif.abort = 1'b1;
        @(negedge clk);
      end
      sif.abort = 1'b0;
      sif.start = 1'b0;
      checks++;
      if (obs !== 4'b0000) begin errors++; $display("FAIL abort_post case %0d got %b want 0000", t, obs); end
      @(negedge clk);
      checks++;
      if (obs !== 4'b0000) begin errors++; $display("FAIL abort_settle case %0d got %b want 0000", t, obs); end
    end

    sif.start = 1'b1; sif.reps = '0; sif.pattern = 4'b1111; sif.gap = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (obs !== 4'b0000) begin errors++; $display("FAIL reps_zero cycle %0d got %b want 0000", k, obs); end
    end

    p = PAT_W'($urandom);
    sif.pattern = p; sif.reps = CNT_W'(1); sif.abort = 1'b1;
    @(negedge clk);
    sif.start = 1'b0; sif.abort = 1'b0;
    exp_q.delete();
    model_transfer(p, 1, 0);
    exp_q.push_back(4'b0000);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs !== exp_q[k]) begin
        errors++;
        $display("FAIL abort_idle cycle %0d got %b want %b", k, obs, exp_q[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    sif.pattern = 4'b1010; sif.reps = CNT_W'(2); sif.gap = GAP_W'(5);
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    exp_q.delete();
    model_transfer(4'b1010, 2, 5);
    for (int k = 0; k <= 5; k++) begin
      checks++;
      if (obs !== exp_q[k]) begin
        errors++;
        $display("FAIL pre_reset cycle %0d got %b want %b", k, obs, exp_q[k]);
      end
      if (k < 5) @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_mid_gap got %b want 0000", obs); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 4'b0000) begin errors++; $display("FAIL reset_no_done got %b want 0000", obs); end

    sif.pattern = 4'b1010; sif.reps = CNT_W'(1); sif.gap = '0;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    exp_q.delete();
    model_transfer(4'b1010, 1, 0);
    exp_q.push_back(4'b0000);
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (obs !== exp_q[k]) begin
        errors++;
        $display("FAIL post_reset cycle %0d got %b want %b", k, obs, exp_q[k]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [PAT_W-1:0] p;
    int r, g, done_idx;
    for (int t = 0; t < 25; t++) begin
      p = PAT_W'($urandom);
      r = int'($urandom_range(1, 15));
      g = int'($urandom_range(0, 7));
      sif.pattern = p; sif.reps = CNT_W'(r); sif.gap = GAP_W'(g);
      sif.start = 1'b1;
      @(negedge clk);
      exp_q.delete();
      model_transfer(p, r, g);
      done_idx = exp_q.size() - 1;
      exp_q.push_back(4'b0000);
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (obs !== exp_q[k]) begin
          errors++;
          $display("FAIL random xfer %0d (p=%b r=%0d g=%0d) cycle %0d got %b want %b",
                   t, p, r, g, k, obs, exp_q[k]);
        end
        // start noise only while busy, where it must be ignored
        sif.start = (k < done_idx) ? 1'($urandom_range(0, 1)) : 1'b0;
        scramble_inputs();
        @(negedge clk);
      end
    end
    sif.start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
